// File: rtl/input_port_router_pkg.sv
// Shared definitions for the router input port: default link widths,
// output-direction encoding and the flit field packing order.
package input_port_router_pkg;

   localparam int DEF_X_W    = 2;
   localparam int DEF_Y_W    = 2;
   localparam int DEF_BANK_W = 8;
   localparam int DEF_DATA_W = 32;
   localparam int NUM_DIRS   = 5;

   typedef enum logic [2:0] {
      DIR_NORTH = 3'd0,
      DIR_SOUTH = 3'd1,
      DIR_EAST  = 3'd2,
      DIR_WEST  = 3'd3,
      DIR_LOCAL = 3'd4
   } dirE;

   // Flit packing, MSB first: {dest, requester, read, write, data}.
   function automatic int flitWidth(input int xW, input int yW, input int bankW, input int dataW);
      return (xW + yW + bankW) + (xW + yW) + 2 + dataW;
   endfunction

endpackage

// File: rtl/input_port_router_flit_fifo.sv
// Circular flit buffer with synchronous write/read and asynchronous reset.
// Head entry is visible combinationally; a push into a full FIFO is ignored.
module flit_fifo #(
   parameter int WIDTH = 50,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pushEn,
   input  logic             popEn,
   input  logic [WIDTH-1:0] pushData,
   output logic [WIDTH-1:0] headData,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   count;
   logic             doPush;
   logic             doPop;

   assign full     = (count == (PTR_W+1)'(DEPTH));
   assign empty    = (count == '0);
   assign doPush   = pushEn && !full;
   assign doPop    = popEn && !empty;
   assign headData = mem[rdPtr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         count <= count + {{PTR_W{1'b0}}, doPush} - {{PTR_W{1'b0}}, doPop};
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/input_port_router.sv
// Receiving end of one router link: buffers request flits, XY-routes the head
// flit and holds its select bit towards one output arbiter until granted.
module input_port_router
   import input_port_router_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int X_W    = DEF_X_W,
   parameter int Y_W    = DEF_Y_W,
   parameter int BANK_W = DEF_BANK_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int MY_X   = 0,
   parameter int MY_Y   = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [X_W+Y_W+BANK_W-1:0] destinationAddressIn,
   input  logic [X_W+Y_W-1:0]        requesterAddressIn,
   input  logic                      readIn,
   input  logic                      writeIn,
   input  logic [DATA_W-1:0]         dataIn,
   output logic                      portFull,
   output logic                      dropFlag,
   input  logic                      grant_NORTH,
   input  logic                      grant_SOUTH,
   input  logic                      grant_EAST,
   input  logic                      grant_WEST,
   input  logic                      grant_LOCAL,
   output logic                      selectBit_NORTH,
   output logic                      selectBit_SOUTH,
   output logic                      selectBit_EAST,
   output logic                      selectBit_WEST,
   output logic                      selectBit_LOCAL,
   output logic [X_W+Y_W+BANK_W-1:0] destinationAddressOut,
   output logic [X_W+Y_W-1:0]        requesterAddressOut,
   output logic                      readOut,
   output logic                      writeOut,
   output logic [DATA_W-1:0]         dataOut
);

   localparam int DEST_W = X_W + Y_W + BANK_W;
   localparam int NODE_W = X_W + Y_W;
   localparam int FLIT_W = flitWidth(X_W, Y_W, BANK_W, DATA_W);
   localparam logic [X_W-1:0] MY_X_C = X_W'(MY_X);
   localparam logic [Y_W-1:0] MY_Y_C = Y_W'(MY_Y);

   // Handshakes: on the link a flit is valid when readIn^writeIn and is taken
   // unless portFull; towards an arbiter selectBit is valid and grant is ready,
   // and the head pops at the edge where both are high.
   logic                pushValid;
   logic                malformed;
   logic                pushReq;
   logic                popReq;
   logic                fifoFull;
   logic                fifoEmpty;
   logic [FLIT_W-1:0]   inFlit;
   logic [FLIT_W-1:0]   headFlit;
   logic [DEST_W-1:0]   headDest;
   logic [NODE_W-1:0]   headReq;
   logic                headRead;
   logic                headWrite;
   logic [DATA_W-1:0]   headData;
   logic [X_W-1:0]      headX;
   logic [Y_W-1:0]      headY;
   dirE                 routeDir;
   logic [NUM_DIRS-1:0] selVec;
   logic [NUM_DIRS-1:0] grantVec;

   assign pushValid = readIn ^ writeIn;
   assign malformed = readIn & writeIn;
   assign pushReq   = pushValid & ~fifoFull;
   assign inFlit    = {destinationAddressIn, requesterAddressIn, readIn, writeIn, dataIn};

   flit_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (DEPTH)
   ) fifo (
      .clk      (clk),
      .reset    (reset),
      .pushEn   (pushReq),
      .popEn    (popReq),
      .pushData (inFlit),
      .headData (headFlit),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   assign {headDest, headReq, headRead, headWrite, headData} = headFlit;
   assign headX = headDest[DEST_W-1 -: X_W];
   assign headY = headDest[BANK_W+Y_W-1 -: Y_W];

   // XY order: resolve X completely before looking at Y.
   always_comb begin
      routeDir = DIR_LOCAL;
      if (headX > MY_X_C)      routeDir = DIR_EAST;
      else if (headX < MY_X_C) routeDir = DIR_WEST;
      else if (headY > MY_Y_C) routeDir = DIR_NORTH;
      else if (headY < MY_Y_C) routeDir = DIR_SOUTH;
   end

   always_comb begin
      selVec = '0;
      if (!fifoEmpty) selVec[routeDir] = 1'b1;
   end

   assign grantVec = {grant_LOCAL, grant_WEST, grant_EAST, grant_SOUTH, grant_NORTH};
   assign popReq   = |(selVec & grantVec);

   assign selectBit_NORTH = selVec[DIR_NORTH];
   assign selectBit_SOUTH = selVec[DIR_SOUTH];
   assign selectBit_EAST  = selVec[DIR_EAST];
   assign selectBit_WEST  = selVec[DIR_WEST];
   assign selectBit_LOCAL = selVec[DIR_LOCAL];

   // Payload is forced to zero when empty so stale buffer contents never leak.
   assign destinationAddressOut = fifoEmpty ? '0 : headDest;
   assign requesterAddressOut   = fifoEmpty ? '0 : headReq;
   assign readOut               = fifoEmpty ? 1'b0 : headRead;
   assign writeOut              = fifoEmpty ? 1'b0 : headWrite;
   assign dataOut               = fifoEmpty ? '0 : headData;
   assign portFull              = fifoFull;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dropFlag <= 1'b0;
      end else if (malformed || (pushValid && fifoFull)) begin
         dropFlag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_input_port_router.sv
// Bench for input_port_router at MY_X=1, MY_Y=1: directed corner cases,
// a routing vector table and random traffic against a queue-based model.
module tb_input_port_router;

   localparam int DEPTH  = 4;
   localparam int DEST_W = 12;
   localparam int NODE_W = 4;
   localparam int DATA_W = 32;
   localparam int W      = DEST_W + NODE_W + 2 + DATA_W;

   logic              clk = 1'b0;
   logic              reset;
   logic [DEST_W-1:0] destinationAddressIn;
   logic [NODE_W-1:0] requesterAddressIn;
   logic              readIn;
   logic              writeIn;
   logic [DATA_W-1:0] dataIn;
   logic              portFull;
   logic              dropFlag;
   logic              grant_NORTH, grant_SOUTH, grant_EAST, grant_WEST, grant_LOCAL;
   logic              selectBit_NORTH, selectBit_SOUTH, selectBit_EAST, selectBit_WEST, selectBit_LOCAL;
   logic [DEST_W-1:0] destinationAddressOut;
   logic [NODE_W-1:0] requesterAddressOut;
   logic              readOut;
   logic              writeOut;
   logic [DATA_W-1:0] dataOut;

   // grant/select vectors are ordered {LOCAL, WEST, EAST, SOUTH, NORTH}
   localparam logic [4:0] G_NONE  = 5'b00000;
   localparam logic [4:0] G_NORTH = 5'b00001;
   localparam logic [4:0] G_SOUTH = 5'b00010;
   localparam logic [4:0] G_EAST  = 5'b00100;
   localparam logic [4:0] G_WEST  = 5'b01000;
   localparam logic [4:0] G_LOCAL = 5'b10000;

   always #5 clk = ~clk;

   input_port_router #(.DEPTH(4), .X_W(2), .Y_W(2), .BANK_W(8), .DATA_W(32), .MY_X(1), .MY_Y(1)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .destinationAddressIn  (destinationAddressIn),
      .requesterAddressIn    (requesterAddressIn),
      .readIn                (readIn),
      .writeIn               (writeIn),
      .dataIn                (dataIn),
      .portFull              (portFull),
      .dropFlag              (dropFlag),
      .grant_NORTH           (grant_NORTH),
      .grant_SOUTH           (grant_SOUTH),
      .grant_EAST            (grant_EAST),
      .grant_WEST            (grant_WEST),
      .grant_LOCAL           (grant_LOCAL),
      .selectBit_NORTH       (selectBit_NORTH),
      .selectBit_SOUTH       (selectBit_SOUTH),
      .selectBit_EAST        (selectBit_EAST),
      .selectBit_WEST        (selectBit_WEST),
      .selectBit_LOCAL       (selectBit_LOCAL),
      .destinationAddressOut (destinationAddressOut),
      .requesterAddressOut   (requesterAddressOut),
      .readOut               (readOut),
      .writeOut              (writeOut),
      .dataOut               (dataOut)
   );

   // ---------------- scoreboard / reference model ----------------
   logic [W-1:0] exp_q[$];
   logic         expDrop;
   int           errors = 0;
   int           checks = 0;

   function automatic logic [DEST_W-1:0] mkDest(input int x, input int y, input int bank);
      return {2'(x), 2'(y), 8'(bank)};
   endfunction

   // Direction as a one-hot select vector, from the XY rule with MY=(1,1).
   function automatic logic [4:0] routeOf(input logic [DEST_W-1:0] dest);
      int dx;
      int dy;
      dx = int'(dest[11:10]);
      dy = int'(dest[9:8]);
      if (dx > 1) return G_EAST;
      if (dx < 1) return G_WEST;
      if (dy > 1) return G_NORTH;
      if (dy < 1) return G_SOUTH;
      return G_LOCAL;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] selNow();
      return {selectBit_LOCAL, selectBit_WEST, selectBit_EAST, selectBit_SOUTH, selectBit_NORTH};
   endfunction

   task automatic checkOutputs();
      logic [W-1:0] h;
      logic [4:0]   expSel;
      h = '0;
      expSel = G_NONE;
      if (exp_q.size() > 0) begin
         h = exp_q[0];
         expSel = routeOf(h[W-1 -: DEST_W]);
      end
      check("selectBits", 64'(selNow()), 64'(expSel));
      check("destOut", 64'(destinationAddressOut), 64'(h[49:38]));
      check("reqOut", 64'(requesterAddressOut), 64'(h[37:34]));
      check("readOut", 64'(readOut), 64'(h[33]));
      check("writeOut", 64'(writeOut), 64'(h[32]));
      check("dataOut", 64'(dataOut), 64'(h[31:0]));
      check("portFull", 64'(portFull), 64'(exp_q.size() == DEPTH));
      check("dropFlag", 64'(dropFlag), 64'(expDrop));
   endtask

   task automatic modelStep(input logic r, input logic w, input logic [W-1:0] flit, input logic [4:0] g);
      logic [W-1:0] h;
      bit valid;
      bit wasFull;
      valid   = r ^ w;
      wasFull = (exp_q.size() == DEPTH);
      if (exp_q.size() > 0) begin
         h = exp_q[0];
         if ((routeOf(h[W-1 -: DEST_W]) & g) != 5'b0) void'(exp_q.pop_front());
      end
      if (valid && !wasFull) exp_q.push_back(flit);
      if ((r && w) || (valid && wasFull)) expDrop = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic w, input logic [DEST_W-1:0] d,
                        input logic [NODE_W-1:0] rq, input logic [DATA_W-1:0] dt, input logic [4:0] g);
      readIn = r;
      writeIn = w;
      destinationAddressIn = d;
      requesterAddressIn = rq;
      dataIn = dt;
      {grant_LOCAL, grant_WEST, grant_EAST, grant_SOUTH, grant_NORTH} = g;
      modelStep(r, w, {d, rq, r, w, dt}, g);
      @(posedge clk);
      #1;
      checkOutputs();
   endtask

   task automatic idle(input logic [4:0] g);
      drive(1'b0, 1'b0, '0, '0, '0, g);
   endtask

   task automatic doReset();
      reset = 1'b1;
      #1;
      exp_q.delete();
      expDrop = 1'b0;
      checkOutputs();
      @(posedge clk);
      #1;
      checkOutputs();
      reset = 1'b0;
   endtask

   typedef struct {
      int         x;
      int         y;
      logic [4:0] expSel;
   } routeVecT;

   routeVecT vecs[8];

   initial begin
      vecs[0] = '{0, 1, G_WEST};
      vecs[1] = '{1, 2, G_NORTH};
      vecs[2] = '{1, 0, G_SOUTH};
      vecs[3] = '{1, 1, G_LOCAL};
      vecs[4] = '{2, 1, G_EAST};
      vecs[5] = '{3, 0, G_EAST};
      vecs[6] = '{0, 3, G_WEST};
      vecs[7] = '{1, 3, G_NORTH};

      reset = 1'b1;
      readIn = 1'b0;
      writeIn = 1'b0;
      destinationAddressIn = '0;
      requesterAddressIn = '0;
      dataIn = '0;
      {grant_LOCAL, grant_WEST, grant_EAST, grant_SOUTH, grant_NORTH} = G_NONE;
      expDrop = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutputs();
      reset = 1'b0;

      // 1: reset mid-stream with two flits queued; a flit offered during reset is lost
      drive(1'b1, 1'b0, mkDest(2, 1, 8'h11), 4'h1, 32'hA1, G_NONE);
      drive(1'b0, 1'b1, mkDest(0, 1, 8'h22), 4'h2, 32'hA2, G_NONE);
      check("t1_queued_sel", 64'(selectBit_EAST), 64'd1);
      reset = 1'b1;
      readIn = 1'b1;
      #1;
      check("t1_reset_sel", 64'(selNow()), 64'd0);
      check("t1_reset_drop", 64'(dropFlag), 64'd0);
      exp_q.delete();
      expDrop = 1'b0;
      @(posedge clk);
      #1;
      checkOutputs();
      reset = 1'b0;
      idle(G_NONE);

      // 2: single flit east, one-cycle latency, pop on grant_EAST
      drive(1'b0, 1'b1, mkDest(2, 1, 8'h05), 4'h3, 32'd10, G_NONE);
      check("t2_sel_east", 64'(selectBit_EAST), 64'd1);
      check("t2_data", 64'(dataOut), 64'd10);
      idle(G_EAST);
      check("t2_popped", 64'(selNow()), 64'd0);

      // 3: streamed routing table, matching grant each cycle
      for (int i = 0; i <= 8; i++) begin
         logic [4:0] g;
         g = (i == 0) ? G_NONE : vecs[i-1].expSel;
         if (i < 8) drive(1'b1, 1'b0, mkDest(vecs[i].x, vecs[i].y, i), 4'(i), 32'(100 + i), g);
         else       idle(g);
         if (i < 8) begin
            check("t3_route", 64'(selNow()), 64'(vecs[i].expSel));
            check("t3_order", 64'(dataOut), 64'(100 + i));
         end else begin
            check("t3_drained", 64'(selNow()), 64'd0);
         end
      end

      // 4: fill, overflow drop, then push+pop at the same edge while full
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, mkDest(2, 1, i), 4'h4, 32'(200 + i), G_NONE);
      check("t4_full", 64'(portFull), 64'd1);
      check("t4_nodrop_yet", 64'(dropFlag), 64'd0);
      drive(1'b1, 1'b0, mkDest(2, 1, 9), 4'h4, 32'd299, G_NONE);
      check("t4_overflow_drop", 64'(dropFlag), 64'd1);
      doReset();
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, mkDest(2, 1, i), 4'h6, 32'(300 + i), G_NONE);
      check("t4_refull", 64'(portFull), 64'd1);
      drive(1'b1, 1'b0, mkDest(2, 1, 7), 4'h6, 32'd399, G_EAST);
      check("t4_popfull_drop", 64'(dropFlag), 64'd1);
      check("t4_popfull_notfull", 64'(portFull), 64'd0);
      check("t4_popfull_head", 64'(dataOut), 64'd301);
      repeat (3) idle(G_EAST);
      check("t4_count3_drained", 64'(selNow()), 64'd0);

      // 5: wrong-direction grant is ignored; payload holds
      drive(1'b1, 1'b0, mkDest(3, 2, 8'h55), 4'h9, 32'hBEEF, G_NONE);
      repeat (3) begin
         idle(G_NORTH);
         check("t5_hold_sel", 64'(selNow()), 64'(G_EAST));
         check("t5_hold_data", 64'(dataOut), 64'hBEEF);
      end
      idle(G_EAST);
      check("t5_popped", 64'(selNow()), 64'd0);

      // 6: malformed flit on an empty port
      doReset();
      drive(1'b1, 1'b1, mkDest(2, 1, 1), 4'h1, 32'h77, G_NONE);
      check("t6_sel", 64'(selNow()), 64'd0);
      check("t6_drop", 64'(dropFlag), 64'd1);

      // random traffic against the model
      doReset();
      for (int i = 0; i < 400; i++) begin
         int mode;
         logic r;
         logic w;
         mode = $urandom_range(0, 9);
         r = 1'b0;
         w = 1'b0;
         if (mode == 0) begin
            r = 1'b1;
            w = 1'b1;
         end else if (mode <= 3) begin
            r = 1'b1;
         end else if (mode <= 6) begin
            w = 1'b1;
         end
         drive(r, w, 12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)),
               $urandom, 5'($urandom_range(0, 31)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
